// File: rtl/oqpsk_shaper_if.sv
// rtl/oqpsk_shaper_if.sv - signal bundle between bit source, sample consumer and oqpsk_shaper_param
`timescale 1ns/1ps
interface oqpsk_shaper_param_if #(
    parameter int DW = 13,
    parameter int AW = 6
);
    logic                 EN;
    logic                 MODE;
    logic                 Bit_In;
    logic                 BIT_VALID;
    logic                 BIT_READY;
    logic                 REQ_SAMPLE;
    logic                 SAMPLE_VALID;
    logic signed [DW-1:0] I;
    logic signed [DW-1:0] Q;
    logic [AW-1:0]        addI;
    logic [AW-1:0]        addQ;
    logic                 COEF_WE;
    logic [AW-1:0]        COEF_ADDR;
    logic signed [DW-1:0] COEF_DATA;
    logic                 UNDERRUN;

    modport master (
        output EN, MODE, Bit_In, BIT_VALID, REQ_SAMPLE, COEF_WE, COEF_ADDR, COEF_DATA,
        input  BIT_READY, SAMPLE_VALID, I, Q, addI, addQ, UNDERRUN
    );

    modport slave (
        input  EN, MODE, Bit_In, BIT_VALID, REQ_SAMPLE, COEF_WE, COEF_ADDR, COEF_DATA,
        output BIT_READY, SAMPLE_VALID, I, Q, addI, addQ, UNDERRUN
    );
endinterface

// File: rtl/oqpsk_shaper_param.sv
// rtl/oqpsk_shaper_param.sv - OQPSK/QPSK baseband shaper with a runtime coefficient table
`timescale 1ns/1ps
module oqpsk_shaper_param #(
    parameter int DW  = 13,
    parameter int SPB = 32,
    parameter int AW  = $clog2(2 * SPB)
) (
    input  logic                CLK,
    input  logic                RST_N,
    oqpsk_shaper_param_if.slave bus
);
    localparam int SYM_LEN = 2 * SPB;
    localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
    localparam logic [AW-1:0] Q_OFFSET = AW'(SPB);

    typedef enum logic [1:0] {SGN_ZERO, SGN_POS, SGN_NEG} sign_t;

    logic signed [DW-1:0] coef [SYM_LEN];
    logic [AW-1:0]        cnt;
    logic                 mode_q;
    logic [1:0]           fifo_cnt;
    logic                 fifo_d0;
    logic                 fifo_d1;
    sign_t                i_sign;
    sign_t                q_sign;
    logic signed [DW-1:0] i_q;
    logic signed [DW-1:0] q_q;
    logic [AW-1:0]        add_i_q;
    logic [AW-1:0]        add_q_q;
    logic                 valid_q;
    logic                 underrun_q;

    logic                 ready;
    logic                 step;
    logic                 push;
    logic                 i_bnd;
    logic                 q_bnd;
    logic                 urun_set;
    logic [1:0]           n_pop;
    logic [1:0]           rem_cnt;
    logic                 rem_d0;
    logic [1:0]           fifo_cnt_nxt;
    logic                 fifo_d0_nxt;
    logic                 fifo_d1_nxt;
    sign_t                i_sign_nxt;
    sign_t                q_sign_nxt;
    logic [AW-1:0]        add_i;
    logic [AW-1:0]        add_q;
    logic signed [DW-1:0] i_val;
    logic signed [DW-1:0] q_val;

    function automatic logic signed [DW-1:0] shape(input sign_t s, input logic signed [DW-1:0] c);
        case (s)
            SGN_POS: shape = c;
            SGN_NEG: shape = (c == MIN_V) ? MAX_V : -c;
            default: shape = '0;
        endcase
    endfunction

    assign ready = bus.EN & (fifo_cnt != 2'd2);
    assign step  = bus.EN & bus.REQ_SAMPLE;
    assign push  = bus.BIT_VALID & ready;
    assign i_bnd = step & (cnt == '0);
    assign q_bnd = step & (mode_q ? (cnt == '0) : (cnt == Q_OFFSET));

    // Pops see only the FIFO contents before this edge; I is served before Q.
    always_comb begin
        n_pop      = 2'd0;
        urun_set   = 1'b0;
        i_sign_nxt = i_sign;
        q_sign_nxt = q_sign;
        if (i_bnd) begin
            if (fifo_cnt != 2'd0) begin
                i_sign_nxt = fifo_d0 ? SGN_NEG : SGN_POS;
                n_pop      = 2'd1;
            end else begin
                i_sign_nxt = SGN_ZERO;
                urun_set   = 1'b1;
            end
        end
        if (q_bnd) begin
            if (fifo_cnt > n_pop) begin
                q_sign_nxt = ((n_pop == 2'd0) ? fifo_d0 : fifo_d1) ? SGN_NEG : SGN_POS;
                n_pop      = n_pop + 2'd1;
            end else begin
                q_sign_nxt = SGN_ZERO;
                urun_set   = 1'b1;
            end
        end
    end

    always_comb begin
        rem_cnt      = fifo_cnt - n_pop;
        rem_d0       = (n_pop == 2'd0) ? fifo_d0 : fifo_d1;
        fifo_cnt_nxt = rem_cnt + {1'b0, push};
        fifo_d0_nxt  = (push && rem_cnt == 2'd0) ? bus.Bit_In : rem_d0;
        fifo_d1_nxt  = (push && rem_cnt == 2'd1) ? bus.Bit_In : fifo_d1;
    end

    always_comb begin
        add_i = cnt;
        add_q = mode_q ? cnt : cnt - Q_OFFSET;
        i_val = shape(i_sign_nxt, coef[add_i]);
        q_val = shape(q_sign_nxt, coef[add_q]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < SYM_LEN; k++) coef[k] <= '0;
        end else if (bus.COEF_WE) begin
            coef[bus.COEF_ADDR] <= bus.COEF_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt        <= '0;
            mode_q     <= 1'b0;
            fifo_cnt   <= 2'd0;
            fifo_d0    <= 1'b0;
            fifo_d1    <= 1'b0;
            i_sign     <= SGN_ZERO;
            q_sign     <= SGN_ZERO;
            i_q        <= '0;
            q_q        <= '0;
            add_i_q    <= '0;
            add_q_q    <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else if (!bus.EN) begin
            cnt        <= '0;
            mode_q     <= bus.MODE;
            fifo_cnt   <= 2'd0;
            fifo_d0    <= 1'b0;
            fifo_d1    <= 1'b0;
            i_sign     <= SGN_ZERO;
            q_sign     <= SGN_ZERO;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            fifo_cnt <= fifo_cnt_nxt;
            fifo_d0  <= fifo_d0_nxt;
            fifo_d1  <= fifo_d1_nxt;
            i_sign   <= i_sign_nxt;
            q_sign   <= q_sign_nxt;
            valid_q  <= step;
            if (urun_set) underrun_q <= 1'b1;
            if (step) begin
                cnt     <= cnt + 1'b1;
                i_q     <= i_val;
                q_q     <= q_val;
                add_i_q <= add_i;
                add_q_q <= add_q;
            end
        end
    end

    assign bus.BIT_READY    = ready;
    assign bus.SAMPLE_VALID = valid_q;
    assign bus.I            = i_q;
    assign bus.Q            = q_q;
    assign bus.addI         = add_i_q;
    assign bus.addQ         = add_q_q;
    assign bus.UNDERRUN     = underrun_q;
endmodule
